// File: rtl/reorder_buffer.sv
// In-order retirement buffer: hands out tags 1..7, collects ALU/memory
// broadcasts, answers operand queries and retires one entry per cycle.
module reorder_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_rd,
  input  logic        alloc_is_store,
  output logic [2:0]  alloc_tag,
  output logic        rob_full,
  input  logic [2:0]  alu_des_in,
  input  logic [31:0] alu_data,
  input  logic        alu_mispredict,
  input  logic [31:0] alu_target,
  input  logic [2:0]  memory_des_in,
  input  logic [31:0] memory_data,
  input  logic [2:0]  query1,
  input  logic [2:0]  query2,
  output logic        q1_ready,
  output logic        q2_ready,
  output logic [31:0] q1_value,
  output logic [31:0] q2_value,
  output logic        commit_valid,
  output logic [2:0]  commit_tag,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_data,
  output logic        commit_is_store,
  output logic        flush_valid,
  output logic [31:0] flush_pc
);

  localparam int DEPTH = 7;

  logic [7:0]  busy_q, busy_d, ready_q, ready_d;
  logic [7:0]  mis_q, mis_d, st_q, st_d;
  logic [4:0]  rd_q  [8];
  logic [4:0]  rd_d  [8];
  logic [31:0] val_q [8];
  logic [31:0] val_d [8];
  logic [31:0] tgt_q [8];
  logic [31:0] tgt_d [8];
  logic [2:0]  head_q, head_d, tail_q, tail_d;
  logic [2:0]  count_q, count_d;

  logic        cv_q, cv_d, cst_q, cst_d, fv_q, fv_d;
  logic [2:0]  ctag_q, ctag_d;
  logic [4:0]  crd_q, crd_d;
  logic [31:0] cdata_q, cdata_d, fpc_q, fpc_d;

  logic do_commit, do_flush, do_alloc;

  function automatic logic [2:0] next_ptr(input logic [2:0] p);
    return (p == 3'(DEPTH)) ? 3'd1 : p + 3'd1;
  endfunction

  // Bypass order: ALU broadcast, then memory broadcast, then stored value
  function automatic logic [32:0] lookup(input logic [2:0] t);
    if (t == 3'd0)
      return {1'b1, 32'd0};
    else if (alu_des_in == t)
      return {1'b1, alu_data};
    else if (memory_des_in == t)
      return {1'b1, memory_data};
    else if (ready_q[t])
      return {1'b1, val_q[t]};
    else
      return 33'd0;
  endfunction

  assign rob_full  = (count_q == 3'(DEPTH));
  assign alloc_tag = tail_q;

  always_comb begin
    {q1_ready, q1_value} = lookup(query1);
    {q2_ready, q2_value} = lookup(query2);
  end

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    mis_d   = mis_q;
    st_d    = st_q;
    rd_d    = rd_q;
    val_d   = val_q;
    tgt_d   = tgt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    cv_d    = 1'b0;
    cst_d   = 1'b0;
    fv_d    = 1'b0;
    ctag_d  = ctag_q;
    crd_d   = crd_q;
    cdata_d = cdata_q;
    fpc_d   = fpc_q;

    do_commit = !pause && busy_q[head_q] && ready_q[head_q];
    do_flush  = do_commit && mis_q[head_q];
    do_alloc  = alloc_valid && !rob_full && !pause && !do_flush;

    if (!pause) begin
      if (memory_des_in != 3'd0 && busy_q[memory_des_in]) begin
        ready_d[memory_des_in] = 1'b1;
        val_d[memory_des_in]   = memory_data;
      end
      if (alu_des_in != 3'd0 && busy_q[alu_des_in]) begin
        ready_d[alu_des_in] = 1'b1;
        val_d[alu_des_in]   = alu_data;
        mis_d[alu_des_in]   = alu_mispredict;
        tgt_d[alu_des_in]   = alu_target;
      end
    end

    if (do_commit) begin
      cv_d    = 1'b1;
      cst_d   = st_q[head_q];
      ctag_d  = head_q;
      crd_d   = st_q[head_q] ? 5'd0 : rd_q[head_q];
      cdata_d = val_q[head_q];
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      mis_d[head_q]   = 1'b0;
      head_d = next_ptr(head_q);
    end

    if (do_alloc) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      mis_d[tail_q]   = 1'b0;
      st_d[tail_q]    = alloc_is_store;
      rd_d[tail_q]    = alloc_rd;
      tail_d = next_ptr(tail_q);
    end

    unique case ({do_alloc, do_commit})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    if (do_flush) begin
      fv_d    = 1'b1;
      fpc_d   = tgt_q[head_q];
      busy_d  = '0;
      ready_d = '0;
      mis_d   = '0;
      head_d  = 3'd1;
      tail_d  = 3'd1;
      count_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q  <= '0;
      ready_q <= '0;
      mis_q   <= '0;
      st_q    <= '0;
      rd_q    <= '{default: '0};
      val_q   <= '{default: '0};
      tgt_q   <= '{default: '0};
      head_q  <= 3'd1;
      tail_q  <= 3'd1;
      count_q <= 3'd0;
      cv_q    <= 1'b0;
      cst_q   <= 1'b0;
      fv_q    <= 1'b0;
      ctag_q  <= 3'd0;
      crd_q   <= 5'd0;
      cdata_q <= 32'd0;
      fpc_q   <= 32'd0;
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      mis_q   <= mis_d;
      st_q    <= st_d;
      rd_q    <= rd_d;
      val_q   <= val_d;
      tgt_q   <= tgt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cv_q    <= cv_d;
      cst_q   <= cst_d;
      fv_q    <= fv_d;
      ctag_q  <= ctag_d;
      crd_q   <= crd_d;
      cdata_q <= cdata_d;
      fpc_q   <= fpc_d;
    end
  end

  assign commit_valid    = cv_q;
  assign commit_tag      = ctag_q;
  assign commit_rd       = crd_q;
  assign commit_data     = cdata_q;
  assign commit_is_store = cst_q;
  assign flush_valid     = fv_q;
  assign flush_pc        = fpc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
// Inputs change 1ns after posedge; outputs are checked before the next edge.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, pause, alloc_valid, alloc_is_store;
  logic [4:0]  alloc_rd;
  logic [2:0]  alloc_tag;
  logic        rob_full;
  logic [2:0]  alu_des_in, memory_des_in, query1, query2;
  logic [31:0] alu_data, alu_target, memory_data;
  logic        alu_mispredict;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic        commit_valid, commit_is_store, flush_valid;
  logic [2:0]  commit_tag;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data, flush_pc;

  int n_cmp = 0;
  int n_bad = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .pause(pause),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_is_store(alloc_is_store),
    .alloc_tag(alloc_tag), .rob_full(rob_full),
    .alu_des_in(alu_des_in), .alu_data(alu_data),
    .alu_mispredict(alu_mispredict), .alu_target(alu_target),
    .memory_des_in(memory_des_in), .memory_data(memory_data),
    .query1(query1), .query2(query2),
    .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_is_store(commit_is_store),
    .flush_valid(flush_valid), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pause = 0; alloc_valid = 0; alloc_rd = 0; alloc_is_store = 0;
    alu_des_in = 0; alu_data = 0; alu_mispredict = 0; alu_target = 0;
    memory_des_in = 0; memory_data = 0; query1 = 0; query2 = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic alloc(input logic [4:0] rd);
    alloc_valid = 1; alloc_rd = rd;
    tick();
    alloc_valid = 0; alloc_rd = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (alloc_tag !== 3'd1) begin n_bad++;
        $display("FAIL reset_tag cyc%0d: got %0d want 1", i, alloc_tag); end
      n_cmp++;
      if (rob_full !== 1'b0) begin n_bad++;
        $display("FAIL reset_full cyc%0d: got %b want 0", i, rob_full); end
      n_cmp++;
      if (commit_valid !== 1'b0) begin n_bad++;
        $display("FAIL reset_cv cyc%0d: got %b want 0", i, commit_valid); end
      tick();
    end
    alloc(5'd1); alloc(5'd2); alloc(5'd3);
    n_cmp++;
    if (alloc_tag !== 3'd4) begin n_bad++;
      $display("FAIL pre_rst_tag: got %0d want 4", alloc_tag); end
    rst = 0; alloc_valid = 1; alloc_rd = 5'd9;
    tick();
    rst = 1; alloc_valid = 0;
    n_cmp++;
    if (alloc_tag !== 3'd1) begin n_bad++;
      $display("FAIL mid_rst_tag: got %0d want 1", alloc_tag); end
    alu_des_in = 3'd1; alu_data = 32'h99;
    tick();
    idle();
    tick();
    n_cmp++;
    if (commit_valid !== 1'b0) begin n_bad++;
      $display("FAIL mid_rst_cv: got %b want 0", commit_valid); end
  endtask

  task automatic test_inorder();
    do_reset();
    alloc(5'd5); alloc(5'd6); alloc(5'd7);
    alu_des_in = 3'd2; alu_data = 32'h22;
    tick();
    alu_des_in = 0; memory_des_in = 3'd1; memory_data = 32'h11;
    n_cmp++;
    if (commit_valid !== 1'b0) begin n_bad++;
      $display("FAIL ino_early1: got %b want 0", commit_valid); end
    tick();
    memory_des_in = 0;
    n_cmp++;
    if (commit_valid !== 1'b0) begin n_bad++;
      $display("FAIL ino_early2: got %b want 0", commit_valid); end
    tick();
    n_cmp++;
    if ({commit_valid, commit_tag, commit_rd, commit_data}
        !== {1'b1, 3'd1, 5'd5, 32'h11}) begin n_bad++;
      $display("FAIL ino_c1: got v%b t%0d rd%0d d%h want v1 t1 rd5 d11",
               commit_valid, commit_tag, commit_rd, commit_data); end
    tick();
    n_cmp++;
    if ({commit_valid, commit_tag, commit_rd, commit_data}
        !== {1'b1, 3'd2, 5'd6, 32'h22}) begin n_bad++;
      $display("FAIL ino_c2: got v%b t%0d rd%0d d%h want v1 t2 rd6 d22",
               commit_valid, commit_tag, commit_rd, commit_data); end
    tick();
    n_cmp++;
    if (commit_valid !== 1'b0) begin n_bad++;
      $display("FAIL ino_hold3: got %b want 0", commit_valid); end
    memory_des_in = 3'd3; memory_data = 32'h33;
    tick();
    memory_des_in = 0;
    tick();
    n_cmp++;
    if ({commit_valid, commit_tag, commit_rd} !== {1'b1, 3'd3, 5'd7})
    begin n_bad++;
      $display("FAIL ino_c3: got v%b t%0d rd%0d want v1 t3 rd7",
               commit_valid, commit_tag, commit_rd); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      n_cmp++;
      if (alloc_tag !== 3'(i)) begin n_bad++;
        $display("FAIL full_tag%0d: got %0d want %0d", i, alloc_tag, i); end
      alloc(5'(i));
    end
    n_cmp++;
    if (rob_full !== 1'b1) begin n_bad++;
      $display("FAIL full_flag: got %b want 1", rob_full); end
    alloc(5'd20);
    n_cmp++;
    if ({rob_full, alloc_tag} !== {1'b1, 3'd1}) begin n_bad++;
      $display("FAIL full_8th: got full%b tag%0d want full1 tag1",
               rob_full, alloc_tag); end
    alu_des_in = 3'd1; alu_data = 32'h77;
    tick();
    alu_des_in = 0;
    tick();
    n_cmp++;
    if ({commit_valid, commit_tag, commit_rd, commit_data}
        !== {1'b1, 3'd1, 5'd1, 32'h77}) begin n_bad++;
      $display("FAIL full_c1: got v%b t%0d rd%0d d%h want v1 t1 rd1 d77",
               commit_valid, commit_tag, commit_rd, commit_data); end
    n_cmp++;
    if ({rob_full, alloc_tag} !== {1'b0, 3'd1}) begin n_bad++;
      $display("FAIL full_drop: got full%b tag%0d want full0 tag1",
               rob_full, alloc_tag); end
    alloc(5'd9);
    n_cmp++;
    if ({rob_full, alloc_tag} !== {1'b1, 3'd2}) begin n_bad++;
      $display("FAIL full_wrap: got full%b tag%0d want full1 tag2",
               rob_full, alloc_tag); end
  endtask

  task automatic test_bypass();
    do_reset();
    alloc(5'd1); alloc(5'd2); alloc(5'd3); alloc(5'd4);
    alu_des_in = 3'd4; alu_data = 32'hABCD;
    memory_des_in = 3'd3; memory_data = 32'h33;
    query1 = 3'd4; query2 = 3'd3;
    #1;
    n_cmp++;
    if ({q1_ready, q1_value} !== {1'b1, 32'hABCD}) begin n_bad++;
      $display("FAIL byp_alu: got r%b v%h want r1 vABCD", q1_ready, q1_value); end
    n_cmp++;
    if ({q2_ready, q2_value} !== {1'b1, 32'h33}) begin n_bad++;
      $display("FAIL byp_mem: got r%b v%h want r1 v33", q2_ready, q2_value); end
    tick();
    alu_des_in = 3'd1; alu_data = 32'hA1;
    memory_des_in = 3'd1; memory_data = 32'hB1;
    query1 = 3'd1; query2 = 3'd2;
    #1;
    n_cmp++;
    if ({q1_ready, q1_value} !== {1'b1, 32'hA1}) begin n_bad++;
      $display("FAIL byp_prio: got r%b v%h want r1 vA1", q1_ready, q1_value); end
    n_cmp++;
    if ({q2_ready, q2_value} !== {1'b0, 32'h0}) begin n_bad++;
      $display("FAIL byp_unres: got r%b v%h want r0 v0", q2_ready, q2_value); end
    tick();
    idle();
    query1 = 3'd4; query2 = 3'd0;
    #1;
    n_cmp++;
    if ({q1_ready, q1_value} !== {1'b1, 32'hABCD}) begin n_bad++;
      $display("FAIL byp_stored: got r%b v%h want r1 vABCD", q1_ready, q1_value); end
    n_cmp++;
    if ({q2_ready, q2_value} !== {1'b1, 32'h0}) begin n_bad++;
      $display("FAIL byp_tag0: got r%b v%h want r1 v0", q2_ready, q2_value); end
    tick();
    n_cmp++;
    if ({commit_valid, commit_tag, commit_data} !== {1'b1, 3'd1, 32'hA1})
    begin n_bad++;
      $display("FAIL byp_aluwins: got v%b t%0d d%h want v1 t1 dA1",
               commit_valid, commit_tag, commit_data); end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 1; i <= 5; i++) alloc(5'(i + 10));
    memory_des_in = 3'd1; memory_data = 32'h10;
    alu_des_in = 3'd2; alu_data = 32'h44;
    alu_mispredict = 1; alu_target = 32'h100;
    tick();
    idle();
    tick();
    n_cmp++;
    if ({commit_valid, commit_tag, flush_valid} !== {1'b1, 3'd1, 1'b0})
    begin n_bad++;
      $display("FAIL mis_c1: got v%b t%0d f%b want v1 t1 f0",
               commit_valid, commit_tag, flush_valid); end
    alloc_valid = 1; alloc_rd = 5'd30;
    tick();
    alloc_valid = 0;
    n_cmp++;
    if ({commit_valid, commit_tag, commit_rd, commit_data}
        !== {1'b1, 3'd2, 5'd12, 32'h44}) begin n_bad++;
      $display("FAIL mis_c2: got v%b t%0d rd%0d d%h want v1 t2 rd12 d44",
               commit_valid, commit_tag, commit_rd, commit_data); end
    n_cmp++;
    if ({flush_valid, flush_pc} !== {1'b1, 32'h100}) begin n_bad++;
      $display("FAIL mis_flush: got f%b pc%h want f1 pc100",
               flush_valid, flush_pc); end
    n_cmp++;
    if ({rob_full, alloc_tag} !== {1'b0, 3'd1}) begin n_bad++;
      $display("FAIL mis_clear: got full%b tag%0d want full0 tag1",
               rob_full, alloc_tag); end
    memory_des_in = 3'd3; memory_data = 32'h3;
    tick();
    idle();
    n_cmp++;
    if ({commit_valid, flush_valid} !== 2'b00) begin n_bad++;
      $display("FAIL mis_pulse: got v%b f%b want v0 f0",
               commit_valid, flush_valid); end
    tick();
    n_cmp++;
    if (commit_valid !== 1'b0) begin n_bad++;
      $display("FAIL mis_stale: got %b want 0", commit_valid); end
  endtask

  task automatic test_pause();
    do_reset();
    alloc(5'd3); alloc(5'd4);
    alu_des_in = 3'd1; alu_data = 32'h55;
    tick();
    idle();
    pause = 1; alloc_valid = 1; alloc_rd = 5'd8; query1 = 3'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (commit_valid !== 1'b0) begin n_bad++;
        $display("FAIL pause_cv%0d: got %b want 0", i, commit_valid); end
      n_cmp++;
      if (alloc_tag !== 3'd3) begin n_bad++;
        $display("FAIL pause_tag%0d: got %0d want 3", i, alloc_tag); end
    end
    n_cmp++;
    if ({q1_ready, q1_value} !== {1'b1, 32'h55}) begin n_bad++;
      $display("FAIL pause_query: got r%b v%h want r1 v55", q1_ready, q1_value); end
    pause = 0; alloc_valid = 0;
    tick();
    n_cmp++;
    if ({commit_valid, commit_tag, commit_rd, commit_data}
        !== {1'b1, 3'd1, 5'd3, 32'h55}) begin n_bad++;
      $display("FAIL pause_c1: got v%b t%0d rd%0d d%h want v1 t1 rd3 d55",
               commit_valid, commit_tag, commit_rd, commit_data); end
  endtask

  task automatic test_store();
    do_reset();
    alloc_is_store = 1;
    alloc(5'd17);
    alloc_is_store = 0;
    memory_des_in = 3'd1; memory_data = 32'hCAFE;
    tick();
    idle();
    tick();
    n_cmp++;
    if ({commit_valid, commit_is_store, commit_rd, commit_data}
        !== {1'b1, 1'b1, 5'd0, 32'hCAFE}) begin n_bad++;
      $display("FAIL store_c: got v%b s%b rd%0d d%h want v1 s1 rd0 dCAFE",
               commit_valid, commit_is_store, commit_rd, commit_data); end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_inorder();
    test_full();
    test_bypass();
    test_mispredict();
    test_pause();
    test_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
